alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's combinational 32-bit ALU. It keeps the existing 13 single-cycle op encodings and adds iterative multiply and unsigned divide/remainder. Inputs use a valid/ready handshake and the result is registered, so the block can sit directly in a multi-cycle execute stage. One operation is in flight at a time.

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_seq_if.sv | 22 ++
 rtl/alu_seq_muldiv.sv | 72 +++++++
 rtl/alu_seq.sv | 114 +++++++++++
 tb/tb_alu_seq.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state constants and op-class helpers for the sequential ALU.
package alu_seq_pkg;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_SLT   = 5'd5;
  localparam logic [4:0] ALU_SLTU  = 5'd6;
  localparam logic [4:0] ALU_LUI   = 5'd7;
  localparam logic [4:0] ALU_ADDU  = 5'd8;
  localparam logic [4:0] ALU_UPB   = 5'd9;
  localparam logic [4:0] ALU_SLL   = 5'd10;
  localparam logic [4:0] ALU_SRA   = 5'd11;
  localparam logic [4:0] ALU_SRL   = 5'd12;
  localparam logic [4:0] ALU_MUL   = 5'd13;
  localparam logic [4:0] ALU_MULHU = 5'd14;
  localparam logic [4:0] ALU_DIVU  = 5'd15;
  localparam logic [4:0] ALU_REMU  = 5'd16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic is_iterative(input logic [4:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  // MULHU and REMU both take the upper half of the shared accumulator
  function automatic logic sel_hi(input logic [4:0] op);
    return (op == ALU_MULHU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between an issuing stage and alu_seq.
interface alu_seq_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result_q;
  logic            out_err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result_q, out_err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result_q, out_err
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative engine: radix-2 shift-add multiply and restoring unsigned divide,
// one bit per cycle over XLEN cycles, sharing one 2*XLEN accumulator.
module alu_seq_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            div,
  input  logic            hi,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic              busy;
  logic              div_q;
  logic              hi_q;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_nx;
  logic [XLEN:0]     msum;
  logic [XLEN:0]     dtrial;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient/dividend}
  always_comb begin
    msum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
    dtrial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
    if (div_q) begin
      if (dtrial[XLEN]) acc_nx = {acc[2*XLEN-2:0], 1'b0};
      else              acc_nx = {dtrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nx = {msum, acc[XLEN-1:1]};
    end
  end

  // The final iteration's value is handed over combinationally so the parent
  // registers it on the same edge, keeping total latency at XLEN+1.
  assign done   = busy && (cnt == CW'(XLEN-1));
  assign result = hi_q ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      div_q <= 1'b0;
      hi_q  <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      div_q <= div;
      hi_q  <= hi;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      opnd <= div ? b : a;
      acc  <= {{XLEN{1'b0}}, (div ? a : b)};
    end else if (busy) begin
      acc <= acc_nx;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops computed inline, MUL/DIV delegated to the
// iterative engine; one operation in flight, result held until taken.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

  logic [1:0]             state;
  logic [XLEN-1:0]        result_r;
  logic                   err_r;
  logic [XLEN-1:0]        alu_y;
  logic [XLEN-1:0]        md_result;
  logic                   md_done;
  logic                   md_start;
  logic                   accept;
  logic                   div_zero;
  logic signed [XLEN-1:0] sa;
  logic signed [XLEN-1:0] sb;

  assign sa = bus.a;
  assign sb = bus.b;

  always_comb begin
    alu_y = '0;
    case (bus.op)
      ALU_ADD:  alu_y = bus.a + bus.b;
      ALU_SUB:  alu_y = bus.a - bus.b;
      ALU_AND:  alu_y = bus.a & bus.b;
      ALU_OR:   alu_y = bus.a | bus.b;
      ALU_XOR:  alu_y = bus.a ^ bus.b;
      ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, (sa < sb)};
      ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
      ALU_LUI:  alu_y = {bus.a[XLEN-13:0], 12'b0};
      ALU_ADDU: alu_y = bus.a + {bus.b[XLEN-13:0], 12'b0};
      ALU_UPB:  alu_y = {bus.b[XLEN-1:12], 12'b0};
      ALU_SLL:  alu_y = bus.a << bus.b[SHW-1:0];
      ALU_SRA:  alu_y = sa >>> bus.b[SHW-1:0];
      ALU_SRL:  alu_y = bus.a >> bus.b[SHW-1:0];
      default:  alu_y = '0;
    endcase
  end

  // A result in DONE can be drained and replaced by a new accept in one cycle
  assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result_q  = result_r;
  assign bus.out_err   = err_r;

  assign accept   = bus.in_valid && bus.in_ready;
  assign div_zero = is_div(bus.op) && (bus.b == '0);
  assign md_start = accept && is_iterative(bus.op) && !div_zero;

  alu_seq_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .div    (is_div(bus.op)),
    .hi     (sel_hi(bus.op)),
    .a      (bus.a),
    .b      (bus.b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      result_r <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (bus.op <= ALU_SRL) begin
              result_r <= alu_y;
              err_r    <= 1'b0;
              state    <= ST_DONE;
            end else if (is_iterative(bus.op)) begin
              err_r <= 1'b0;
              if (div_zero) begin
                // Divide by zero: quotient saturates to all ones, remainder is the dividend
                result_r <= (bus.op == ALU_DIVU) ? {XLEN{1'b1}} : bus.a;
                state    <= ST_DONE;
              end else begin
                state <= is_div(bus.op) ? ST_DIV : ST_MUL;
              end
            end else begin
              result_r <= '0;
              err_r    <= 1'b1;
              state    <= ST_DONE;
            end
          end else if ((state == ST_DONE) && bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_MUL, ST_DIV: begin
          if (md_done) begin
            result_r <= md_result;
            state    <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized bench for alu_seq at XLEN=32 and XLEN=16, checked
// against an arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.XLEN(32)) b32 ();
  alu_seq_if #(.XLEN(16)) b16 ();

  alu_seq #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  alu_seq #(.XLEN(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    e = 1'b0;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6:  r = (a < b) ? 32'd1 : 32'd0;
      7:  r = a * 32'd4096;
      8:  r = a + b * 32'd4096;
      9:  r = b & 32'hFFFF_F000;
      10: r = a << (b % 32);
      11: r = 32'($signed(a) >>> (b % 32));
      12: r = a >> (b % 32);
      13: r = p[31:0];
      14: r = p[63:32];
      15: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      16: r = (b == 0) ? a : a % b;
      default: begin r = 32'd0; e = 1'b1; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [63:0] b, input int w);
    if (op >= 13 && op <= 16 && !((op == 15 || op == 16) && b == 0)) return w + 1;
    return 1;
  endfunction

  task automatic run32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic err, output int lat, output logic busy_ok);
    int w;
    @(negedge clk);
    b32.op = op; b32.a = a; b32.b = b; b32.in_valid = 1'b1; b32.out_ready = 1'b1;
    w = 0;
    while (!b32.in_ready && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    b32.in_valid = 1'b0;
    b32.op = 5'($urandom); b32.a = $urandom; b32.b = $urandom;
    lat = 1; busy_ok = 1'b1;
    while (!b32.out_valid && lat < 100) begin
      if (b32.in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = b32.result_q;
    err = b32.out_err;
  endtask

  task automatic do32(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res, er;
    logic        err, ee, busy_ok;
    int          lat;
    run32(op, a, b, res, err, lat, busy_ok);
    model32(op, a, b, er, ee);
    check({tag, " result"}, res, er);
    check({tag, " err"}, err, ee);
    check({tag, " latency"}, lat, exp_lat(op, b, 32));
    if (lat > 1) check({tag, " in_ready busy"}, busy_ok, 1'b1);
  endtask

  task automatic do16(input string tag, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    int          lat;
    @(negedge clk);
    b16.op = op; b16.a = a; b16.b = b; b16.in_valid = 1'b1; b16.out_ready = 1'b1;
    @(negedge clk);
    b16.in_valid = 1'b0; b16.a = 16'($urandom); b16.b = 16'($urandom);
    lat = 1;
    while (!b16.out_valid && lat < 100) begin @(negedge clk); lat++; end
    p = 32'(a) * 32'(b);
    check({tag, " result"}, b16.result_q, (op == ALU_MULHU) ? p[31:16] : p[15:0]);
    check({tag, " latency"}, lat, 17);
  endtask

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    logic        seen;

    b32.in_valid = 1'b0; b32.op = '0; b32.a = '0; b32.b = '0; b32.out_ready = 1'b0;
    b16.in_valid = 1'b0; b16.op = '0; b16.a = '0; b16.b = '0; b16.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst out_valid", b32.out_valid, 1'b0);
    check("rst result_q", b32.result_q, 32'd0);
    check("rst out_err", b32.out_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst in_ready", b32.in_ready, 1'b1);
    check("rst in_ready16", b16.in_ready, 1'b1);

    do32("add", ALU_ADD, 32'd10, 32'd3);
    do32("sra", ALU_SRA, 32'h8000_0000, 32'd1);
    do32("mul", ALU_MUL, 32'h1234_5678, 32'h10);
    do32("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do32("divu", ALU_DIVU, 32'd100, 32'd7);
    do32("remu", ALU_REMU, 32'd100, 32'd7);
    do32("divu0", ALU_DIVU, 32'd5, 32'd0);
    do32("remu0", ALU_REMU, 32'd5, 32'd0);

    // Backpressure: result held while the consumer stalls
    @(negedge clk);
    b32.op = ALU_SUB; b32.a = 32'd5; b32.b = 32'd10; b32.in_valid = 1'b1; b32.out_ready = 1'b0;
    @(negedge clk);
    b32.in_valid = 1'b0; b32.a = $urandom;
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", b32.out_valid, 1'b1);
      check("bp result", b32.result_q, 32'hFFFF_FFFB);
      check("bp in_ready", b32.in_ready, 1'b0);
      @(negedge clk);
    end
    b32.out_ready = 1'b1; b32.in_valid = 1'b1;
    b32.op = ALU_AND; b32.a = 32'hF0F0_F0F0; b32.b = 32'h0F0F_0F0F;
    #1;
    check("b2b in_ready", b32.in_ready, 1'b1);
    @(negedge clk);
    b32.in_valid = 1'b0;
    check("b2b out_valid", b32.out_valid, 1'b1);
    check("b2b result", b32.result_q, 32'd0);

    do32("illegal", 5'd20, 32'h1234, 32'h5678);
    do32("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd5);

    // Reset in the middle of a divide
    @(negedge clk);
    b32.op = ALU_DIVU; b32.a = 32'd1000; b32.b = 32'd3; b32.in_valid = 1'b1; b32.out_ready = 1'b1;
    @(negedge clk);
    b32.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", b32.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort in_ready", b32.in_ready, 1'b1);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (b32.out_valid) seen = 1'b1; end
    check("abort no result", seen, 1'b0);
    do32("add post-rst", ALU_ADD, 32'hFFFF_FFFF, 32'd2);

    for (int i = 0; i < 60; i++) begin
      rop = 5'($urandom_range(0, 20));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb % 64;
      do32($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb);
    end

    do16("mul16", ALU_MUL, 16'h1234, 16'h0010);
    do16("mulhu16", ALU_MULHU, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 8; i++)
      do16($sformatf("rnd16_%0d", i), (i % 2 == 0) ? ALU_MUL : ALU_MULHU, 16'($urandom), 16'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
